// File: rtl/game_pkg.sv
// Shared types and constants for the Pong round sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b01;
  localparam logic [1:0] WIN_R    = 2'b10;

  localparam int WIN_SCORE_DEFAULT = 5;

  // True on the cycle a level signal goes from low to high.
  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle of game_ctrl control inputs and per-frame enable outputs.
interface game_ctrl_if;

  logic       frame_tick;
  logic       start_btn;
  logic       pause_btn;
  logic       miss_left;
  logic       miss_right;
  logic [2:0] state;
  logic       ball_en;
  logic       ball_rst;
  logic       paddle_en;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] winner;

  // Input/ball logic side: drives events, observes sequencer outputs.
  modport master (
    output frame_tick, start_btn, pause_btn, miss_left, miss_right,
    input  state, ball_en, ball_rst, paddle_en, serve_dir,
           score_l, score_r, winner
  );

  // Sequencer side.
  modport slave (
    input  frame_tick, start_btn, pause_btn, miss_left, miss_right,
    output state, ball_en, ball_rst, paddle_en, serve_dir,
           score_l, score_r, winner
  );

endinterface

// File: rtl/game_ctrl_frame_timer.sv
// Down-counter of frame ticks. Shared by the serve hold and the
// post-point freeze; the owner reloads it on entry to either phase.
module frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             frame_tick,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Load has priority, so a tick arriving with the load is not counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (frame_tick && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  // The last tick of the period; the owner changes state on this edge.
  assign done = frame_tick && (cnt == ONE);

endmodule

// File: rtl/game_ctrl.sv
// Pong round sequencer: serve hold, play, pause, point freeze and game
// over, with score keeping and registered enables for ball and paddles.
module game_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEFAULT,
  parameter int SERVE_FRAMES = 120,
  parameter int POINT_FRAMES = 60,
  parameter int CNT_W        = 8
) (
  input logic        clk,
  input logic        rst,
  game_ctrl_if.slave bus
);

  // Refuse to build with parameters the sequencer cannot honour.
  generate
    if (SERVE_FRAMES < 1 || POINT_FRAMES < 1) begin : g_bad_frames
      $error("game_ctrl: SERVE_FRAMES and POINT_FRAMES must be at least 1");
    end
    if (SERVE_FRAMES >= (1 << CNT_W) || POINT_FRAMES >= (1 << CNT_W)) begin : g_bad_cnt_w
      $error("game_ctrl: CNT_W too narrow for the frame counts");
    end
    if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win
      $error("game_ctrl: WIN_SCORE must be in 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] POINT_LD = CNT_W'(POINT_FRAMES);
  localparam logic [3:0]       WIN_VAL  = 4'(WIN_SCORE);
  localparam logic [3:0]       ONE_PT   = 4'd1;

  game_state_t state_q, state_n;
  logic [3:0]  score_l_q, score_l_n;
  logic [3:0]  score_r_q, score_r_n;
  logic [1:0]  winner_q, winner_n;
  logic        serve_dir_q, serve_dir_n;
  logic        ball_en_q, ball_en_n;
  logic        ball_rst_q, ball_rst_n;
  logic        paddle_en_q, paddle_en_n;
  logic        start_q, pause_q;

  logic             start_edge, pause_edge;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_done;

  assign start_edge = rise(bus.start_btn, start_q);
  assign pause_edge = rise(bus.pause_btn, pause_q);

  frame_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_val   (tmr_load_val),
    .frame_tick (bus.frame_tick),
    .done       (tmr_done)
  );

  // State, scores, button history and decoded enables all update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= WIN_NONE;
      serve_dir_q <= 1'b1;
      ball_en_q   <= 1'b0;
      ball_rst_q  <= 1'b1;
      paddle_en_q <= 1'b0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      score_l_q   <= score_l_n;
      score_r_q   <= score_r_n;
      winner_q    <= winner_n;
      serve_dir_q <= serve_dir_n;
      ball_en_q   <= ball_en_n;
      ball_rst_q  <= ball_rst_n;
      paddle_en_q <= paddle_en_n;
      start_q     <= bus.start_btn;
      pause_q     <= bus.pause_btn;
    end
  end

  // Round sequencing; enables are decoded from the next state so they
  // register in the same cycle as the state itself.
  always_comb begin
    state_n      = state_q;
    score_l_n    = score_l_q;
    score_r_n    = score_r_q;
    winner_n     = winner_q;
    serve_dir_n  = serve_dir_q;
    tmr_load     = 1'b0;
    tmr_load_val = SERVE_LD;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_n   = SERVE;
          score_l_n = '0;
          score_r_n = '0;
          winner_n  = WIN_NONE;
          tmr_load  = 1'b1;
        end
      end

      SERVE: begin
        if (tmr_done) begin
          state_n = PLAY;
        end
      end

      PLAY: begin
        if (bus.miss_left && bus.miss_right) begin
          state_n  = SERVE;
          tmr_load = 1'b1;
        end else if (bus.miss_left) begin
          score_r_n    = score_r_q + ONE_PT;
          serve_dir_n  = 1'b0;
          state_n      = POINT;
          tmr_load     = 1'b1;
          tmr_load_val = POINT_LD;
        end else if (bus.miss_right) begin
          score_l_n    = score_l_q + ONE_PT;
          serve_dir_n  = 1'b1;
          state_n      = POINT;
          tmr_load     = 1'b1;
          tmr_load_val = POINT_LD;
        end else if (pause_edge) begin
          state_n = PAUSE;
        end
      end

      PAUSE: begin
        if (pause_edge) begin
          state_n = PLAY;
        end
      end

      POINT: begin
        if (tmr_done) begin
          if (score_l_q == WIN_VAL) begin
            state_n  = OVER;
            winner_n = WIN_L;
          end else if (score_r_q == WIN_VAL) begin
            state_n  = OVER;
            winner_n = WIN_R;
          end else begin
            state_n  = SERVE;
            tmr_load = 1'b1;
          end
        end
      end

      OVER: begin
        if (start_edge) begin
          state_n     = SERVE;
          score_l_n   = '0;
          score_r_n   = '0;
          winner_n    = WIN_NONE;
          serve_dir_n = 1'b1;
          tmr_load    = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    ball_en_n   = (state_n == PLAY);
    ball_rst_n  = (state_n == IDLE) || (state_n == SERVE) ||
                  (state_n == POINT) || (state_n == OVER);
    paddle_en_n = (state_n == SERVE) || (state_n == PLAY);
  end

  assign bus.state     = state_q;
  assign bus.ball_en   = ball_en_q;
  assign bus.ball_rst  = ball_rst_q;
  assign bus.paddle_en = paddle_en_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a rule-level model predicts each
// cycle's outputs into a queue, and a monitor pops and compares them.
module tb_game_ctrl;
  import game_pkg::*;

  localparam int SF = 3;
  localparam int PF = 2;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  game_ctrl_if bus();

  game_ctrl #(
    .WIN_SCORE    (WS),
    .SERVE_FRAMES (SF),
    .POINT_FRAMES (PF),
    .CNT_W        (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int st;
    int ben;
    int brst;
    int pen;
    int dir;
    int sl;
    int sr;
    int win;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: game rules in terms of phase, frames left, points.
  game_state_t m_state = IDLE;
  int   m_left = 0;
  int   m_sl   = 0;
  int   m_sr   = 0;
  int   m_win  = 0;
  int   m_dir  = 1;
  logic m_prev_s = 1'b0;
  logic m_prev_p = 1'b0;

  logic cur_start = 1'b0;
  logic cur_pause = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic newServe();
    m_state = SERVE;
    m_left  = SF;
  endtask

  task automatic modelStep(input logic r, input logic t, input logic s,
                           input logic p, input logic ml, input logic mr);
    logic se, pe;
    if (!r) begin
      m_state = IDLE; m_left = 0; m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1;
      m_prev_s = 1'b0; m_prev_p = 1'b0;
      return;
    end
    se = s && !m_prev_s;
    pe = p && !m_prev_p;
    m_prev_s = s;
    m_prev_p = p;
    if (m_state == IDLE) begin
      if (se) begin m_sl = 0; m_sr = 0; m_win = 0; newServe(); end
    end else if (m_state == SERVE) begin
      if (t) begin
        m_left--;
        if (m_left == 0) m_state = PLAY;
      end
    end else if (m_state == PLAY) begin
      if (ml && mr) newServe();
      else if (ml) begin m_sr++; m_dir = 0; m_state = POINT; m_left = PF; end
      else if (mr) begin m_sl++; m_dir = 1; m_state = POINT; m_left = PF; end
      else if (pe) m_state = PAUSE;
    end else if (m_state == PAUSE) begin
      if (pe) m_state = PLAY;
    end else if (m_state == POINT) begin
      if (t) begin
        m_left--;
        if (m_left == 0) begin
          if (m_sl == WS)      begin m_state = OVER; m_win = 1; end
          else if (m_sr == WS) begin m_state = OVER; m_win = 2; end
          else newServe();
        end
      end
    end else if (m_state == OVER) begin
      if (se) begin m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1; newServe(); end
    end
  endtask

  // One clock of stimulus, driven at the falling edge; prediction queued.
  task automatic applyStimulus(input logic r, input logic t, input logic s,
                               input logic p, input logic ml, input logic mr);
    exp_t e;
    rst            = r;
    bus.frame_tick = t;
    bus.start_btn  = s;
    bus.pause_btn  = p;
    bus.miss_left  = ml;
    bus.miss_right = mr;
    modelStep(r, t, s, p, ml, mr);
    e.st   = int'(m_state);
    e.ben  = (m_state == PLAY) ? 1 : 0;
    e.brst = (m_state == IDLE || m_state == SERVE || m_state == POINT || m_state == OVER) ? 1 : 0;
    e.pen  = (m_state == SERVE || m_state == PLAY) ? 1 : 0;
    e.dir  = m_dir;
    e.sl   = m_sl;
    e.sr   = m_sr;
    e.win  = m_win;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, cur_start, cur_pause, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      applyStimulus(1'b1, 1'b1, cur_start, cur_pause, 1'b0, 1'b0);
      idle(1);
    end
  endtask

  task automatic pressStart();
    cur_start = 1'b1; idle(1);
    cur_start = 1'b0; idle(1);
  endtask

  // Monitor: compare each registered output set shortly after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("sb_state",     int'(bus.state),     e.st);
      checkOutput("sb_ball_en",   int'(bus.ball_en),   e.ben);
      checkOutput("sb_ball_rst",  int'(bus.ball_rst),  e.brst);
      checkOutput("sb_paddle_en", int'(bus.paddle_en), e.pen);
      checkOutput("sb_serve_dir", int'(bus.serve_dir), e.dir);
      checkOutput("sb_score_l",   int'(bus.score_l),   e.sl);
      checkOutput("sb_score_r",   int'(bus.score_r),   e.sr);
      checkOutput("sb_winner",    int'(bus.winner),    e.win);
    end
  end

  initial begin
    bus.frame_tick = 1'b0;
    bus.start_btn  = 1'b0;
    bus.pause_btn  = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    @(negedge clk);

    // Reset
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_state", int'(bus.state), 0);
    checkOutput("rst_ball_rst", int'(bus.ball_rst), 1);
    checkOutput("rst_serve_dir", int'(bus.serve_dir), 1);

    // Start, serve hold of exactly 3 ticks
    pressStart();
    checkOutput("serve_state", int'(bus.state), 1);
    checkOutput("serve_paddle_en", int'(bus.paddle_en), 1);
    ticks(2);
    checkOutput("serve_still", int'(bus.state), 1);
    ticks(1);
    checkOutput("play_state", int'(bus.state), 2);
    checkOutput("play_ball_en", int'(bus.ball_en), 1);

    // Right miss scores for left
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("point_state", int'(bus.state), 4);
    checkOutput("point_score_l", int'(bus.score_l), 1);
    checkOutput("point_paddle_en", int'(bus.paddle_en), 0);
    ticks(2);
    checkOutput("point_to_serve", int'(bus.state), 1);
    ticks(3);

    // Left reaches winning score
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(2);
    checkOutput("over_state", int'(bus.state), 5);
    checkOutput("over_winner", int'(bus.winner), 1);
    pressStart();
    checkOutput("restart_state", int'(bus.state), 1);
    checkOutput("restart_score_l", int'(bus.score_l), 0);
    checkOutput("restart_winner", int'(bus.winner), 0);
    ticks(3);

    // Simultaneous misses
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("both_miss_state", int'(bus.state), 1);
    checkOutput("both_miss_score_r", int'(bus.score_r), 0);
    ticks(3);

    // Pause held, misses ignored, second edge resumes
    cur_pause = 1'b1; idle(10);
    checkOutput("pause_state", int'(bus.state), 3);
    checkOutput("pause_ball_rst", int'(bus.ball_rst), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, cur_pause, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, cur_pause, 1'b0, 1'b1);
    cur_pause = 1'b0; idle(1);
    checkOutput("pause_hold", int'(bus.state), 3);
    cur_pause = 1'b1; idle(1);
    checkOutput("resume_state", int'(bus.state), 2);
    checkOutput("pause_scores", int'(bus.score_l) + int'(bus.score_r), 0);
    cur_pause = 1'b0; idle(1);

    // Reset mid-point, then start edges during serve are ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("mid_score_r", int'(bus.score_r), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_state", int'(bus.state), 0);
    checkOutput("midrst_score_r", int'(bus.score_r), 0);
    checkOutput("midrst_ball_rst", int'(bus.ball_rst), 1);
    pressStart();
    for (int i = 0; i < SF; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i < SF - 1) begin
        cur_start = 1'b1; idle(1);
        cur_start = 1'b0; idle(1);
      end
    end
    checkOutput("serve_restart_ignored", int'(bus.state), 2);

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) cur_start = ~cur_start;
      if ($urandom_range(0, 7) == 0) cur_pause = ~cur_pause;
      applyStimulus(($urandom_range(0, 399) != 0),
                    ($urandom_range(0, 3) == 0),
                    cur_start, cur_pause,
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 15) == 0));
    end
    cur_start = 1'b0; cur_pause = 1'b0;
    idle(2);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Top-level Pong round sequencer. It decides when the ball is held at centre, when it moves, and when paddles may move, and it counts points from miss events. It tallies both players' scores and declares a winner. It sits between the input/ball logic and the draw_rect/ball drawing blocks and drives their enables and resets once per frame.

Parameters:
WIN_SCORE, 5, points needed to win (1..15)
SERVE_FRAMES, 120, frame ticks the ball is held at centre before play
POINT_FRAMES, 60, frame ticks of freeze after a point
CNT_W, 8, frame counter width (must hold max of the two frame counts)

Ports:
clk  in  1  system (pixel) clock
rst  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse per frame (start of vblank), generated upstream
start_btn  in  1  debounced, synchronised start button (level)
pause_btn  in  1  debounced, synchronised pause button (level)
miss_left  in  1  one-cycle pulse: ball passed left paddle
miss_right  in  1  one-cycle pulse: ball passed right paddle
state  out  3  current game_state_t (debug/overlay)
ball_en  out  1  ball may move
ball_rst  out  1  hold ball at screen centre
paddle_en  out  1  paddles may move
serve_dir  out  1  0 = serve toward left, 1 = toward right
score_l  out  4  left player score
score_r  out  4  right player score
winner  out  2  00 none, 01 left, 10 right

Behaviour:
- All outputs registered. Reset (rst==0 at clk edge): state=IDLE, scores 0, ball_en=0, ball_rst=1, paddle_en=0, serve_dir=1, winner=00, counter 0, edge-detect history regs 0.
- Rising-edge detect on start_btn and pause_btn (1-cycle registered history). Only edges act; held buttons never retrigger.
- States: IDLE, SERVE, PLAY, PAUSE, POINT, OVER.
- IDLE: start edge -> SERVE. Scores clear, winner=00, counter=SERVE_FRAMES.
- SERVE: counter decrements on each frame_tick. A tick with counter==1 -> PLAY next cycle, so the state lasts exactly SERVE_FRAMES ticks. Misses and pause are ignored.
- PLAY: a miss_left pulse sets score_r+1 and serve_dir=0 (serve toward the loser), then -> POINT with counter=POINT_FRAMES. miss_right mirrors this: score_l+1, serve_dir=1.
- PLAY, both misses in the same cycle: no score change, serve_dir unchanged, -> SERVE with counter=SERVE_FRAMES.
- PLAY: pause edge -> PAUSE. A miss in the same cycle as a pause edge takes priority (pause is ignored).
- PAUSE: pause edge -> PLAY. Ball position is preserved (ball_rst=0, ball_en=0). Misses are ignored.
- POINT: counts POINT_FRAMES ticks, as in SERVE. At expiry, if score_l==WIN_SCORE or score_r==WIN_SCORE -> OVER with winner set; otherwise -> SERVE with counter=SERVE_FRAMES.
- OVER: scores and winner are held. Start edge -> SERVE, with scores cleared, winner=00 and serve_dir=1.
- Output decode, registered with state so it changes in the same cycle:
  - ball_en = PLAY.
  - ball_rst = IDLE, SERVE, POINT or OVER.
  - paddle_en = SERVE or PLAY.
- Start edges in SERVE, PLAY, PAUSE and POINT are ignored.
- Miss pulses outside PLAY are ignored.
- A frame_tick in the same cycle a counter is loaded is not counted.
- Scores cannot exceed WIN_SCORE; no wrap-around handling is needed.
- Reset asserted in any state returns to IDLE on that edge. No partial score is kept.
- SERVE_FRAMES or POINT_FRAMES = 0 is illegal; this is checked by an elaboration assertion.

Decomposition:
- game_pkg: game_state_t (3-bit enum IDLE=0, SERVE, PLAY, PAUSE, POINT, OVER), winner encoding constants WIN_NONE/WIN_L/WIN_R, default WIN_SCORE.
- Sub-module frame_timer: load value, frame_tick in, done pulse out, CNT_W parameter. It is instanced once and reused for both SERVE and POINT.

Test Plan:
Bench settings: SERVE_FRAMES=3, POINT_FRAMES=2, WIN_SCORE=2.
1. Reset, then start edge -> SERVE with ball_rst=1, paddle_en=1. After exactly 3 frame_ticks -> PLAY with ball_en=1, ball_rst=0.
2. In PLAY, miss_right pulse -> score_l=1, serve_dir=1, state POINT, paddle_en=0. After 2 ticks -> SERVE.
3. Drive left to score 2 -> after POINT expiry, state=OVER, winner=01. A start edge -> SERVE with score_l=score_r=0, winner=00.
4. miss_left and miss_right in the same cycle in PLAY -> scores unchanged, state SERVE, serve_dir unchanged.
5. Pause edge in PLAY -> PAUSE with ball_en=0, ball_rst=0. Holding pause_btn high for 10 cycles causes no toggle. Release, then a second edge -> PLAY. Miss pulses during PAUSE leave scores at 0.
6. rst=0 mid-POINT with score_r=1 -> next edge shows IDLE, scores 0, ball_rst=1. Start edges during SERVE are ignored: the counter is not reloaded, and PLAY still begins after 3 ticks.
